bsg_dmc_ui_burst_adapter: RTL

Upstream front end for `bsg_dmc` in the `ui_clk` domain. It takes one whole-burst request (write or read, full burst of data and byte masks) over a valid/ready handshake and drives the beat-level `app_*` user interface of the DMC. Read beats are collected into one whole-burst response held on a valid/ready port. Replaces hand-sequenced `app_*` driving in traffic generators and client logic; one transaction in flight at a time.

---
 rtl/bsg_dmc_ui_burst_adapter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bsg_dmc_ui_burst_adapter.sv
// Whole-burst request/response front end for the DMC app_* beat interface.
// One transaction in flight; read beats are reassembled into the request buffer.

package bsg_dmc_ui_burst_adapter_pkg;
  typedef enum logic [2:0] {
    WR = 3'b000,
    RD = 3'b001
  } app_cmd_e;
endpackage

// state  | meaning
// IDLE   | waiting for a request (gated by calibration)
// WDATA  | streaming write beats on the wdf channel
// WCMD   | issuing the WR command after all beats are accepted
// RCMD   | issuing the RD command
// RDATA  | collecting read beats until the end beat
// RESP   | presenting the assembled read burst
module bsg_dmc_ui_burst_adapter
  import bsg_dmc_ui_burst_adapter_pkg::*;
#(
  parameter int ui_addr_width_p   = 28,
  parameter int ui_data_width_p   = 32,
  parameter int ui_burst_length_p = 8,
  localparam int burst_data_width_lp = ui_data_width_p * ui_burst_length_p,
  localparam int ui_mask_width_lp    = ui_data_width_p >> 3,
  localparam int burst_mask_width_lp = burst_data_width_lp >> 3
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           init_calib_complete_i,

  input  logic                           req_v_i,
  output logic                           req_ready_o,
  input  logic                           req_write_i,
  input  logic [ui_addr_width_p-1:0]     req_addr_i,
  input  logic [burst_data_width_lp-1:0] req_data_i,
  input  logic [burst_mask_width_lp-1:0] req_mask_i,

  output logic                           resp_v_o,
  input  logic                           resp_ready_i,
  output logic [burst_data_width_lp-1:0] resp_data_o,

  output logic [ui_addr_width_p-1:0]     app_addr_o,
  output app_cmd_e                       app_cmd_o,
  output logic                           app_en_o,
  input  logic                           app_rdy_i,

  output logic                           app_wdf_wren_o,
  output logic [ui_data_width_p-1:0]     app_wdf_data_o,
  output logic [ui_mask_width_lp-1:0]    app_wdf_mask_o,
  output logic                           app_wdf_end_o,
  input  logic                           app_wdf_rdy_i,

  input  logic                           app_rd_data_valid_i,
  input  logic [ui_data_width_p-1:0]     app_rd_data_i,
  input  logic                           app_rd_data_end_i,

  output logic                           error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WCMD,
    S_RCMD,
    S_RDATA,
    S_RESP
  } state_e;

  localparam int cnt_width_lp = $clog2(ui_burst_length_p);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(ui_burst_length_p - 1);

  state_e                         r_state;
  logic [cnt_width_lp-1:0]        r_cnt;
  logic [ui_addr_width_p-1:0]     r_addr;
  logic [burst_data_width_lp-1:0] r_data;
  logic [burst_mask_width_lp-1:0] r_mask;
  logic                           r_app_en;
  app_cmd_e                       r_app_cmd;
  logic                           r_wdf_wren;
  logic                           r_wdf_end;
  logic                           r_resp_v;
  logic                           r_error;

  logic                           w_req_fire;
  logic [cnt_width_lp-1:0]        w_cnt_inc;
  logic                           w_cnt_last;

  assign req_ready_o = init_calib_complete_i & (r_state == S_IDLE);
  assign w_req_fire  = req_v_i & req_ready_o;
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_cnt_last  = (r_cnt == last_cnt_lp);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_app_en   <= 1'b0;
      r_app_cmd  <= WR;
      r_wdf_wren <= 1'b0;
      r_wdf_end  <= 1'b0;
      r_resp_v   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      // the read channel has no backpressure, so a beat we are not expecting is lost
      if (app_rd_data_valid_i && (r_state != S_RDATA))
        r_error <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_req_fire) begin
            r_addr <= req_addr_i;
            r_data <= req_data_i;
            r_mask <= req_mask_i;
            r_cnt  <= '0;
            if (req_write_i) begin
              r_state    <= S_WDATA;
              r_wdf_wren <= 1'b1;
              r_wdf_end  <= 1'b0;
            end else begin
              r_state   <= S_RCMD;
              r_app_en  <= 1'b1;
              r_app_cmd <= RD;
            end
          end
        end

        S_WDATA: begin
          if (app_wdf_rdy_i) begin
            if (w_cnt_last) begin
              r_state    <= S_WCMD;
              r_cnt      <= '0;
              r_wdf_wren <= 1'b0;
              r_wdf_end  <= 1'b0;
              r_app_en   <= 1'b1;
              r_app_cmd  <= WR;
            end else begin
              r_cnt     <= w_cnt_inc;
              r_wdf_end <= (w_cnt_inc == last_cnt_lp);
            end
          end
        end

        S_WCMD: begin
          if (app_rdy_i) begin
            r_state  <= S_IDLE;
            r_app_en <= 1'b0;
          end
        end

        S_RCMD: begin
          if (app_rdy_i) begin
            r_state  <= S_RDATA;
            r_app_en <= 1'b0;
            r_cnt    <= '0;
          end
        end

        S_RDATA: begin
          if (app_rd_data_valid_i) begin
            r_data[r_cnt*ui_data_width_p +: ui_data_width_p] <= app_rd_data_i;
            r_cnt <= w_cnt_inc;
            if (app_rd_data_end_i != w_cnt_last)
              r_error <= 1'b1;
            if (app_rd_data_end_i) begin
              r_state  <= S_RESP;
              r_resp_v <= 1'b1;
            end
          end
        end

        S_RESP: begin
          if (resp_ready_i) begin
            r_state  <= S_IDLE;
            r_resp_v <= 1'b0;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_app_en   <= 1'b0;
          r_wdf_wren <= 1'b0;
          r_wdf_end  <= 1'b0;
          r_resp_v   <= 1'b0;
        end
      endcase
    end
  end

  assign app_addr_o     = r_addr;
  assign app_cmd_o      = r_app_cmd;
  assign app_en_o       = r_app_en;
  assign app_wdf_wren_o = r_wdf_wren;
  assign app_wdf_end_o  = r_wdf_end;
  assign app_wdf_data_o = r_data[r_cnt*ui_data_width_p +: ui_data_width_p];
  assign app_wdf_mask_o = r_mask[r_cnt*ui_mask_width_lp +: ui_mask_width_lp];
  assign resp_v_o       = r_resp_v;
  assign resp_data_o    = r_data;
  assign error_o        = r_error;

endmodule
